// File: rtl/ddr_scheduler.sv
// ddr_scheduler: single-port DDR command scheduler arbitrating refresh, read and write requests.
// Ports: clock_i/reset_i (sync, active-high); init_done_i gates all service;
//   rfc_req_i/rfc_start_o/rfc_done_i refresh handshake; cmd_* ACTIVE/column command interface;
//   rd_*/wr_* level requests with {bank,row,col} address, len = words-1, one-cycle ack; busy_o = not IDLE.
// Build option: define SCHED_FAIR_EN for alternating read/write grants, otherwise read has priority.
module ddr_scheduler #(
    parameter int LEN_BITS = 4
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                init_done_i,
    input  logic                rfc_req_i,
    output logic                rfc_start_o,
    input  logic                rfc_done_i,
    output logic                cmd_start_o,
    output logic                cmd_read_o,
    output logic                cmd_last_o,
    input  logic                cmd_active_i,
    input  logic                cmd_exec_i,
    output logic [1:0]          cmd_bank_o,
    output logic [12:0]         cmd_row_o,
    output logic [7:0]          cmd_col_o,
    input  logic                rd_req_i,
    input  logic [22:0]         rd_addr_i,
    input  logic [LEN_BITS-1:0] rd_len_i,
    output logic                rd_ack_o,
    input  logic                wr_req_i,
    input  logic [22:0]         wr_addr_i,
    input  logic [LEN_BITS-1:0] wr_len_i,
    output logic                wr_ack_o,
    output logic                busy_o
);
    typedef enum logic [1:0] {IDLE, REFRESH, ACTIVATE, XFER} state_t;
    state_t state, state_n;
    logic [LEN_BITS-1:0] rem;
    logic rd_sel, grant_rd, grant_wr, rfc_go;
`ifdef SCHED_FAIR_EN
    logic last_wr;
    // read wins a tie only when write was served last; a lone request always wins
    assign rd_sel = rd_req_i && (!wr_req_i || last_wr);
    always_ff @(posedge clock_i) begin
        if (reset_i)
            last_wr <= 1'b1;
        else if (grant_rd || grant_wr)
            last_wr <= grant_wr;
    end
`else
    assign rd_sel = rd_req_i;
`endif
    assign cmd_start_o = state == ACTIVATE;
    assign cmd_last_o  = state == XFER && rem == '0;
    assign busy_o      = state != IDLE;
    always_comb begin
        state_n  = state;
        rfc_go   = 1'b0;
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        case (state)
            IDLE: if (init_done_i) begin
                rfc_go   = rfc_req_i;
                grant_rd = !rfc_req_i && rd_sel;
                grant_wr = !rfc_req_i && !rd_sel && wr_req_i;
                state_n  = rfc_req_i ? REFRESH : (grant_rd || grant_wr) ? ACTIVATE : IDLE;
            end
            REFRESH:  state_n = rfc_done_i ? IDLE : REFRESH;
            ACTIVATE: state_n = cmd_active_i ? XFER : ACTIVATE;
            XFER:     state_n = (cmd_exec_i && rem == '0) ? IDLE : XFER;
            default:  state_n = IDLE;
        endcase
    end
    // acks and refresh start are registered one-cycle pulses issued on the decision edge
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state       <= IDLE;
            rfc_start_o <= 1'b0;
            rd_ack_o    <= 1'b0;
            wr_ack_o    <= 1'b0;
            cmd_read_o  <= 1'b0;
            cmd_bank_o  <= '0;
            cmd_row_o   <= '0;
            cmd_col_o   <= '0;
            rem         <= '0;
        end else begin
            state       <= state_n;
            rfc_start_o <= rfc_go;
            rd_ack_o    <= grant_rd;
            wr_ack_o    <= grant_wr;
            if (grant_rd || grant_wr) begin
                {cmd_bank_o, cmd_row_o, cmd_col_o} <= grant_rd ? rd_addr_i : wr_addr_i;
                rem        <= grant_rd ? rd_len_i : wr_len_i;
                cmd_read_o <= grant_rd;
            end else if (state == XFER && cmd_exec_i) begin
                cmd_col_o <= cmd_col_o + 8'd1;
                rem       <= rem - LEN_BITS'(1);
            end
        end
    end
endmodule
